// File: rtl/dcim_bitserial_core.sv
// Bit-serial digital compute-in-memory MAC sequencer: walks input bits MSB first,
// shift-accumulates per-channel partial sums. Optional macro DCIM_CORE_SAT_EN clamps results.
module dcim_bitserial_core #(
  parameter int NCH  = 2,
  parameter int MACW = 15,
  parameter int ACCW = 51
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 inwidth,
  input  logic                 wwidth,
  input  logic                 sus,
  input  logic                 acm_en,
  output logic [2:0]           sel,
  output logic                 sel_valid,
  output logic                 busy,
  input  logic [NCH*MACW-1:0]  macout_low,
  input  logic [NCH*MACW-1:0]  macout_high,
  output logic [NCH*ACCW-1:0]  nout,
  output logic                 nout_valid,
  input  logic                 nout_ready
);

  // state   | meaning
  // IDLE    | waiting for start
  // COMPUTE | one input bit per cycle, sel = bit index
  // DONE    | result presented until accepted
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

`ifdef DCIM_CORE_SAT_EN
  // Working accumulator is wide enough never to wrap, so the clamp sees the true sum.
  localparam int IW = ((ACCW > MACW + 13) ? ACCW : MACW + 13) + 1;
  localparam logic signed [IW:0] MAXV = (IW+1)'((64'sd1 <<< (ACCW-1)) - 64'sd1);
  localparam logic signed [IW:0] MINV = (IW+1)'(-(64'sd1 <<< (ACCW-1)));
`else
  localparam int IW = ACCW;
`endif

  state_t state, state_nxt;
  logic inw_q, ww_q, sus_q, acm_q;
  logic [2:0] cnt;
  logic [2:0] top;
  logic accept, step, finish;
  logic [NCH*ACCW-1:0] nout_q, nout_nxt;
  logic signed [IW-1:0]   part    [NCH];
  logic signed [IW-1:0]   acc     [NCH];
  logic signed [IW-1:0]   acc_nxt [NCH];
  logic signed [ACCW-1:0] prev    [NCH];
`ifdef DCIM_CORE_SAT_EN
  logic signed [IW:0]     sum     [NCH];
`endif

  assign top  = inw_q ? 3'd7 : 3'd3;
  assign nout = nout_q;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    sel        = 3'd0;
    sel_valid  = 1'b0;
    busy       = 1'b0;
    nout_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        sel       = cnt;
        sel_valid = 1'b1;
        busy      = 1'b1;
        step      = 1'b1;
        if (cnt == 3'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        nout_valid = 1'b1;
        if (nout_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      part[c] = IW'($signed(macout_low[c*MACW +: MACW]));
      if (ww_q) part[c] = part[c] + (IW'($signed(macout_high[c*MACW +: MACW])) <<< 4);
      // In signed mode the MSB carries negative weight.
      if (sus_q && (cnt == top)) acc_nxt[c] = -part[c];
      else                       acc_nxt[c] = (acc[c] <<< 1) + part[c];
      prev[c] = acm_q ? $signed(nout_q[c*ACCW +: ACCW]) : '0;
    end
  end

  always_comb begin
    nout_nxt = '0;
    for (int c = 0; c < NCH; c++) begin
`ifdef DCIM_CORE_SAT_EN
      sum[c] = (IW+1)'(acc_nxt[c]) + (IW+1)'(prev[c]);
      if (sum[c] > MAXV)      nout_nxt[c*ACCW +: ACCW] = MAXV[ACCW-1:0];
      else if (sum[c] < MINV) nout_nxt[c*ACCW +: ACCW] = MINV[ACCW-1:0];
      else                    nout_nxt[c*ACCW +: ACCW] = sum[c][ACCW-1:0];
`else
      nout_nxt[c*ACCW +: ACCW] = acc_nxt[c] + prev[c];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inw_q  <= 1'b0;
      ww_q   <= 1'b0;
      sus_q  <= 1'b0;
      acm_q  <= 1'b0;
      cnt    <= 3'd0;
      nout_q <= '0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else if (accept) begin
      inw_q <= inwidth;
      ww_q  <= wwidth;
      sus_q <= sus;
      acm_q <= acm_en;
      cnt   <= inwidth ? 3'd7 : 3'd3;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else if (step) begin
      cnt <= cnt - 3'd1;
      for (int c = 0; c < NCH; c++) acc[c] <= acc_nxt[c];
      if (finish) nout_q <= nout_nxt;
    end
  end

endmodule

// File: tb/tb_dcim_bitserial_core.sv
// Scoreboard bench for dcim_bitserial_core: default instance plus a 12-bit-result
// instance driven in lockstep; directed vectors with hand-computed results.
module tb_dcim_bitserial_core;
  localparam int NCH = 2, MACW = 15, ACCW = 51, ACCW12 = 12;
`ifdef DCIM_CORE_SAT_EN
  localparam longint R1 = 2047, R2 = 2047;
`else
  localparam longint R1 = 494, R2 = 988;
`endif

  typedef struct { longint c0; longint c1; } exp_t;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic inwidth = 1'b0, wwidth = 1'b0, sus = 1'b0, acm_en = 1'b0, nout_ready = 1'b1;
  logic [NCH*MACW-1:0] macout_low = '0, macout_high = '0;
  logic [2:0] sel, sel12;
  logic sel_valid, busy, nout_valid, sel_valid12, busy12, nout_valid12;
  logic [NCH*ACCW-1:0]   nout;
  logic [NCH*ACCW12-1:0] nout12;

  int vecs = 0, fails = 0;
  exp_t q[$], q12[$];

  always #5 clk = ~clk;

  dcim_bitserial_core #(.NCH(NCH), .MACW(MACW), .ACCW(ACCW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .inwidth(inwidth), .wwidth(wwidth),
    .sus(sus), .acm_en(acm_en), .sel(sel), .sel_valid(sel_valid), .busy(busy),
    .macout_low(macout_low), .macout_high(macout_high), .nout(nout),
    .nout_valid(nout_valid), .nout_ready(nout_ready));

  dcim_bitserial_core #(.NCH(NCH), .MACW(MACW), .ACCW(ACCW12)) dut12 (
    .clk(clk), .rstn(rstn), .start(start), .inwidth(inwidth), .wwidth(wwidth),
    .sus(sus), .acm_en(acm_en), .sel(sel12), .sel_valid(sel_valid12), .busy(busy12),
    .macout_low(macout_low), .macout_high(macout_high), .nout(nout12),
    .nout_valid(nout_valid12), .nout_ready(nout_ready));

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per handshake for each instance.
  always @(negedge clk) begin : mon
    exp_t x;
    if (rstn && nout_valid && nout_ready) begin
      if (q.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        x = q.pop_front();
        chk("nout_ch0", $signed(nout[0 +: ACCW]), x.c0);
        chk("nout_ch1", $signed(nout[ACCW +: ACCW]), x.c1);
      end
    end
    if (rstn && nout_valid12 && nout_ready) begin
      if (q12.size() == 0) chk("sb12_unexpected", 1, 0);
      else begin
        x = q12.pop_front();
        chk("nout12_ch0", $signed(nout12[0 +: ACCW12]), x.c0);
        chk("nout12_ch1", $signed(nout12[ACCW12 +: ACCW12]), x.c1);
      end
    end
  end

  task automatic run(input bit iw, input bit ww, input bit su, input bit acm,
                     input logic signed [14:0] l0, input logic signed [14:0] h0,
                     input logic signed [14:0] l1, input logic signed [14:0] h1,
                     input longint e0, input longint e1, input longint f0, input longint f1,
                     input int hold);
    int nb;
    exp_t x;
    nb = iw ? 8 : 4;
    @(negedge clk);
    inwidth = iw; wwidth = ww; sus = su; acm_en = acm;
    macout_low = {l1, l0}; macout_high = {h1, h0};
    start = 1'b1;
    x.c0 = e0; x.c1 = e1; q.push_back(x);
    x.c0 = f0; x.c1 = f1; q12.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
    inwidth = ~iw; wwidth = ~ww; sus = ~su; acm_en = ~acm;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      chk("sel", longint'(sel), longint'(nb - 1 - i));
      chk("sel_valid", longint'(sel_valid), 1);
      chk("valid_early", longint'(nout_valid), 0);
    end
    @(negedge clk);
    chk("valid_latency", longint'(nout_valid), 1);
    chk("sel_idle_done", longint'(sel), 0);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk);
        chk("hold_valid", longint'(nout_valid), 1);
        chk("hold_nout", $signed(nout[0 +: ACCW]), e0);
      end
      @(posedge clk); #1 nout_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("busy_after", longint'(busy), 0);
    chk("sel_valid_after", longint'(sel_valid), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(nout_valid), 0);
    chk("rst_nout", longint'(nout[63:0]), 0);
    @(posedge clk); #1 rstn = 1'b1;

    run(0, 0, 0, 0, 15'sd3, 15'sd0, 15'sd0, 15'sd0, 45, 0, 45, 0, 0);
    run(0, 0, 1, 0, 15'sd3, 15'sd0, 15'sd0, 15'sd0, -3, 0, -3, 0, 0);
    run(1, 1, 0, 0, 15'sd0, 15'sd0, 15'sd2, 15'sd1, 0, 4590, 0, R1, 0);
    run(0, 0, 0, 0, 15'sd3, 15'sd0, 15'sd0, 15'sd0, 45, 0, 45, 0, 0);
    nout_ready = 1'b0;
    run(0, 0, 0, 1, 15'sd3, 15'sd0, 15'sd0, 15'sd0, 90, 0, 90, 0, 5);

    // Reset in the third COMPUTE cycle.
    @(negedge clk);
    inwidth = 1'b0; wwidth = 1'b0; sus = 1'b0; acm_en = 1'b0;
    macout_low = {15'sd0, 15'sd3}; macout_high = '0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sel", longint'(sel), 1);
    rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_sel", longint'(sel), 0);
    chk("mid_rst_sel_valid", longint'(sel_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_valid", longint'(nout_valid), 0);
    chk("mid_rst_nout", longint'(nout[63:0]), 0);
    chk("mid_rst_nout12", longint'(nout12), 0);

    run(0, 0, 0, 1, 15'sd3, 15'sd0, 15'sd0, 15'sd0, 45, 0, 45, 0, 0);
    run(1, 1, 0, 1, 15'sd0, 15'sd0, 15'sd2, 15'sd1, 45, 4590, 45, R1, 0);
    run(1, 1, 0, 1, 15'sd0, 15'sd0, 15'sd2, 15'sd1, 45, 9180, 45, R2, 0);

    repeat (3) @(negedge clk);
    chk("sb_drain", longint'(q.size() + q12.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d, miscompares %0d", vecs, fails + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcim_bitserial_core.md
DCIM_BITSERIAL_CORE -- requirements
Module: dcim_bitserial_core

Interface
REQ-001 Parameter NCH, default 2, number of independent MAC output channels.
REQ-002 Parameter MACW, default 15, width of each signed per-channel MAC partial sum.
REQ-003 Parameter ACCW, default 51, width of each signed per-channel accumulated result.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, synchronous and active-low.
REQ-006 start  input  1  start request, sampled only in IDLE.
REQ-007 inwidth  input  1  input precision: 0 = 4-bit, 1 = 8-bit; captured at accepted start.
REQ-008 wwidth  input  1  weight precision: 0 = 4-bit (low half only), 1 = 8-bit (high and low); captured at start.
REQ-009 sus  input  1  1 = signed two's-complement inputs, 0 = unsigned; captured at start.
REQ-010 acm_en  input  1  1 = add previous result to new result; captured at start.
REQ-011 sel  output  3  input bit index driven to the word-line driver.
REQ-012 sel_valid  output  1  high while sel is meaningful (COMPUTE).
REQ-013 busy  output  1  high in COMPUTE and DONE.
REQ-014 macout_low  input  NCH*MACW  signed low-weight partial sums from the array, channel c at bits [c*MACW +: MACW].
REQ-015 macout_high  input  NCH*MACW  signed high-weight partial sums, same packing.
REQ-016 nout  output  NCH*ACCW  signed results, channel c at bits [c*ACCW +: ACCW].
REQ-017 nout_valid  output  1  result valid; held until accepted.
REQ-018 nout_ready  input  1  consumer accepts result when nout_valid and nout_ready are both high.

Function
REQ-019 States: IDLE, COMPUTE, DONE.
REQ-020 IDLE: start=1 latches the mode inputs, clears the working accumulators, loads the bit counter with NB-1 (NB = 4 or 8), and moves to COMPUTE.
REQ-021 COMPUTE: sel = bit counter, MSB first (NB-1 down to 0); macout is combinational from sel and is sampled in the same cycle.
REQ-022 Per-channel partial: wwidth=0 gives P = sext(low); wwidth=1 gives P = sext(high)*16 + sext(low); P is computed at ACCW width.
REQ-023 Per cycle: acc = (acc << 1) + P, except when sus=1 and sel=NB-1, where acc = -P.
REQ-024 After the sel=0 cycle, the block moves to DONE and loads nout = acc + (acm_en ? previous nout : 0), using wrap-around modulo 2^ACCW.
REQ-025 DONE: nout_valid=1 and nout is stable; on nout_valid and nout_ready the block moves to IDLE next cycle and nout keeps its value as "previous".
REQ-026 Latency: start accepted in cycle T gives COMPUTE in cycles T+1..T+NB and nout_valid from cycle T+NB+1.
REQ-027 start in COMPUTE or DONE is ignored, including in the same cycle as the DONE handshake; it is not queued.
REQ-028 The mode inputs change nothing after start is accepted.
REQ-029 sel = 0 and sel_valid = 0 outside COMPUTE.

Reset
REQ-030 rstn=0 at any clock edge, including mid-COMPUTE or in DONE, gives state IDLE, sel=0, sel_valid=0, busy=0, nout_valid=0, nout=0, all accumulators and the latched mode bits cleared.
REQ-031 After reset, the first acm_en=1 operation adds 0 as the previous result.

Configuration
REQ-032 Macro DCIM_CORE_SAT_EN defined: the REQ-024 final sum is computed at ACCW+1 bits and clamped per channel to [-2^(ACCW-1), 2^(ACCW-1)-1].
REQ-033 Macro DCIM_CORE_SAT_EN undefined: the final sum wraps modulo 2^ACCW with no saturation logic.

Verification
REQ-034 inwidth=0, sus=0, wwidth=0, ch0 low=3 constant, start -> sel 3,2,1,0 then nout ch0 = 45, nout_valid at T+5.
REQ-035 Same as REQ-034 with sus=1 -> nout ch0 = -3 (-24+12+6+3).
REQ-036 inwidth=1, sus=0, wwidth=1, ch1 high=1 low=2 -> ch1 = 18*255 = 4590, nout_valid at T+9.
REQ-037 Run REQ-034 and handshake, then repeat with acm_en=1 -> 90; hold nout_ready=0 for 5 cycles -> nout_valid and nout stay stable, and start during the hold is ignored.
REQ-038 rstn=0 during the third COMPUTE cycle -> next cycle IDLE with all outputs 0; a following acm_en=1 run of REQ-034 -> 45.
REQ-039 ACCW=12, acm_en=1, repeated REQ-036 runs (4590, then 9180) -> with DCIM_CORE_SAT_EN the second run gives 2047 (the first run gives 2047 too, since 4590 exceeds the 12-bit range); without the macro the first run gives 4590 mod 4096 = 494 and the second gives 9180 mod 4096 = 988.
